// File: rtl/median_feeder.sv
// Raster-scan 3x3 window feeder for a serial median stage: buffers two lines, streams each
// interior window as nine pixels, then waits (bounded) for the stage's result.
module median_feeder #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TMO   = 63
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [SIZE-1:0] PIX_IN,
  input  logic            PIX_VAL,
  input  logic            SOF,
  output logic            PIX_RDY,
  output logic [SIZE-1:0] MED_DI,
  output logic            MED_DSI,
  input  logic [SIZE-1:0] MED_DO,
  input  logic            MED_DSO,
  output logic [SIZE-1:0] RES_OUT,
  output logic            RES_VAL,
  output logic            RES_ERR
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CntW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StOut} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0]   res_q, res_d;
  logic              rdy_q;

  logic [SIZE-1:0]   lb0_q [WIDTH];
  logic [SIZE-1:0]   lb1_q [WIDTH];
  logic [SIZE-1:0]   win_q [9];
  logic [SIZE-1:0]   win_d [9];

  logic              accept;
  logic              win_ok;

  assign accept = PIX_VAL && PIX_RDY;

  // Position of the pixel being accepted; row saturates since only r>=2 matters.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (SOF) begin
        col_d = '0;
        row_d = '0;
      end else if (col_q == ColW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == 2'd2) ? 2'd2 : row_q + 2'd1;
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  assign win_ok = accept && (row_d == 2'd2) && (col_d >= ColW'(2));

  // New right column uses the line buffers before this pixel overwrites them.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3]     = win_q[r*3 + 1];
        win_d[r*3 + 1] = win_q[r*3 + 2];
      end
      win_d[2] = lb1_q[col_d];
      win_d[5] = lb0_q[col_d];
      win_d[8] = PIX_IN;
    end
  end

  always_ff @(posedge CLK) begin
    win_q <= win_d;
    if (accept) begin
      lb1_q[col_d] <= lb0_q[col_d];
      lb0_q[col_d] <= PIX_IN;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      StIdle: begin
        if (win_ok) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        if (idx_q == 4'd8) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (MED_DSO) begin
          res_d   = MED_DO;
          state_d = StOut;
        end else if (cnt_q == CntW'(TMO - 1)) begin
          state_d = StIdle;
        end
      end
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    PIX_RDY = (state_q == StIdle) && rdy_q;
    MED_DSI = (state_q == StLoad);
    MED_DI  = MED_DSI ? win_q[idx_q] : '0;
    RES_VAL = (state_q == StOut);
    RES_ERR = (state_q == StWait) && !MED_DSO && (cnt_q == CntW'(TMO - 1));
  end

  assign RES_OUT = res_q;

endmodule

// File: tb/tb_median_feeder.sv
// Bench for median_feeder: behavioural median stage, scoreboard of expected medians computed
// from the bench's own image, and scenario tasks for framing, timeout and reset behaviour.
module tb_median_feeder;

  localparam int WIDTH = 16;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [7:0] PIX_IN;
  logic       PIX_VAL;
  logic       SOF;
  logic       PIX_RDY;
  logic [7:0] MED_DI;
  logic       MED_DSI;
  logic [7:0] MED_DO;
  logic       MED_DSO;
  logic [7:0] RES_OUT;
  logic       RES_VAL;
  logic       RES_ERR;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb [$];
  logic [7:0] last_exp = 8'd0;
  logic [7:0] res_hist [$];
  logic [7:0] acc_hist [$];
  logic [7:0] di_hist [$];
  logic [7:0] src_q [$];
  int         dsi_start_acc [$];
  int         err_cyc [$];
  int         cyc;
  int         acc_total;
  int         run;
  int         last_dsi_cyc;
  bit         err_allowed = 1'b0;
  bit         model_en = 1'b1;
  logic [7:0] img [4][16];

  median_feeder #(
    .SIZE (8),
    .WIDTH(WIDTH),
    .TMO  (63)
  ) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .PIX_IN (PIX_IN),
    .PIX_VAL(PIX_VAL),
    .SOF    (SOF),
    .PIX_RDY(PIX_RDY),
    .MED_DI (MED_DI),
    .MED_DSI(MED_DSI),
    .MED_DO (MED_DO),
    .MED_DSO(MED_DSO),
    .RES_OUT(RES_OUT),
    .RES_VAL(RES_VAL),
    .RES_ERR(RES_ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] median_of(input logic [71:0] v);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
      end
    end
    return a[4];
  endfunction

  // Median stage model: collects nine DI values, answers after 1..3 cycles unless disabled.
  initial begin
    logic [7:0]  mbuf [9];
    logic [71:0] pk;
    logic [7:0]  mres;
    int          mcnt;
    int          mlat;
    MED_DSO = 1'b0;
    MED_DO  = 8'd0;
    mcnt    = 0;
    mlat    = -1;
    mres    = 8'd0;
    forever begin
      @(negedge CLK);
      MED_DSO = 1'b0;
      MED_DO  = 8'd0;
      if (!nRST) begin
        mcnt = 0;
        mlat = -1;
      end else begin
        if (mlat > 0) begin
          mlat--;
          if (mlat == 0) begin
            if (model_en) begin
              MED_DSO = 1'b1;
              MED_DO  = mres;
            end
            mlat = -1;
          end
        end
        if (MED_DSI) begin
          mbuf[mcnt] = MED_DI;
          mcnt++;
          if (mcnt == 9) begin
            for (int k = 0; k < 9; k++) pk[k*8 +: 8] = mbuf[k];
            mres = median_of(pk);
            mcnt = 0;
            mlat = $urandom_range(1, 3);
          end
        end
      end
    end
  end

  // Monitor and scoreboard checker, sampling on the falling edge.
  initial begin
    logic [7:0] exp;
    cyc = 0; acc_total = 0; run = 0; last_dsi_cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!nRST) begin
        run = 0;
      end else begin
        if (PIX_VAL && PIX_RDY) begin
          acc_hist.push_back(PIX_IN);
          acc_total++;
        end
        if (MED_DSI) begin
          if (run == 0) dsi_start_acc.push_back(acc_total);
          di_hist.push_back(MED_DI);
          run++;
          last_dsi_cyc = cyc;
        end else if (run != 0) begin
          checks++;
          if (run != 9) begin
            failures++;
            $display("FAIL dsi_run: MED_DSI high for %0d cycles, required 9", run);
          end
          run = 0;
        end
        if (MED_DSI || RES_VAL) begin
          checks++;
          if (PIX_RDY !== 1'b0) begin
            failures++;
            $display("FAIL pix_rdy_busy: PIX_RDY=%b while busy, required 0", PIX_RDY);
          end
        end
        if (RES_VAL) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL res_unexpected: RES_VAL with RES_OUT=%0d, required no result", RES_OUT);
          end else begin
            exp = sb.pop_front();
            if (RES_OUT !== exp) begin
              failures++;
              $display("FAIL res_value: RES_OUT=%0d, required %0d", RES_OUT, exp);
            end
          end
          res_hist.push_back(RES_OUT);
        end
        if (RES_ERR) begin
          err_cyc.push_back(cyc);
          checks++;
          if (!err_allowed) begin
            failures++;
            $display("FAIL err_unexpected: RES_ERR=1, required 0");
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_pixel(input logic [7:0] pix, input logic sof);
    int  n = 0;
    bit  done = 1'b0;
    PIX_IN  = pix;
    SOF     = sof;
    PIX_VAL = 1'b1;
    while (!done) begin
      @(negedge CLK);
      if (PIX_RDY === 1'b1) done = 1'b1;
      else begin
        n++;
        if (n > 300) begin
          checks++;
          failures++;
          $display("FAIL send_timeout: PIX_RDY=%b after %0d cycles, required 1", PIX_RDY, n);
          done = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    if (n > 0) begin
      PIX_VAL = 1'b0;
      SOF     = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_img(input int nrows, input int last_col, input bit gaps, input bit expect_res);
    logic [71:0] v;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if (r < nrows - 1 || c <= last_col) begin
          send_pixel(img[r][c], (r == 0 && c == 0));
          src_q.push_back(img[r][c]);
          if (expect_res && r >= 2 && c >= 2) begin
            for (int k = 0; k < 9; k++) v[k*8 +: 8] = img[r - 2 + k/3][c - 2 + k%3];
            last_exp = median_of(v);
            sb.push_back(last_exp);
          end
          if (gaps) idle_cycles($urandom_range(0, 2));
        end
      end
    end
    PIX_VAL = 1'b0;
    SOF     = 1'b0;
  endtask

  task automatic wait_idle(output int left);
    int n = 0;
    while ((sb.size() != 0 || PIX_RDY !== 1'b1) && n < 400) begin
      @(posedge CLK);
      #1;
      n++;
    end
    repeat (2) @(posedge CLK);
    #1;
    left = sb.size();
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < WIDTH; c++) img[r][c] = 8'(16 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < WIDTH; c++) img[r][c] = 8'($urandom_range(1, 255));
  endtask

  task automatic test_reset();
    #1 nRST = 1'b0;
    #2;
    checks++; if (PIX_RDY !== 1'b0) begin failures++; $display("FAIL reset_pix_rdy: %b, required 0", PIX_RDY); end
    checks++; if (MED_DSI !== 1'b0) begin failures++; $display("FAIL reset_dsi: %b, required 0", MED_DSI); end
    checks++; if (MED_DI !== 8'd0) begin failures++; $display("FAIL reset_di: %0d, required 0", MED_DI); end
    checks++; if (RES_OUT !== 8'd0) begin failures++; $display("FAIL reset_res_out: %0d, required 0", RES_OUT); end
    checks++; if (RES_VAL !== 1'b0) begin failures++; $display("FAIL reset_res_val: %b, required 0", RES_VAL); end
    checks++; if (RES_ERR !== 1'b0) begin failures++; $display("FAIL reset_res_err: %b, required 0", RES_ERR); end
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (PIX_RDY !== 1'b1) begin failures++; $display("FAIL release_pix_rdy: %b, required 1", PIX_RDY); end
    checks++; if (MED_DSI !== 1'b0) begin failures++; $display("FAIL release_dsi: %b, required 0", MED_DSI); end
  endtask

  task automatic test_frame();
    int rb = res_hist.size();
    int left;
    int cnt;
    fill_ramp();
    send_img(4, 15, 1'b1, 1'b1);
    wait_idle(left);
    cnt = res_hist.size() - rb;
    checks++; if (left != 0) begin failures++; $display("FAIL frame_drain: %0d outstanding, required 0", left); end
    checks++; if (cnt != 28) begin failures++; $display("FAIL frame_count: %0d results, required 28", cnt); end
    checks++; if (res_hist[rb] !== 8'd17) begin failures++; $display("FAIL frame_first: %0d, required 17", res_hist[rb]); end
    checks++; if (res_hist[rb + cnt - 1] !== 8'd46) begin failures++; $display("FAIL frame_last: %0d, required 46", res_hist[rb + cnt - 1]); end
  endtask

  task automatic test_window_order();
    int db = di_hist.size();
    int left;
    logic [7:0] e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < WIDTH; c++) img[r][c] = 8'd0;
    for (int k = 0; k < 9; k++) img[k/3][k%3] = 8'(9 - k);
    send_img(3, 2, 1'b0, 1'b1);
    wait_idle(left);
    checks++; if (left != 0) begin failures++; $display("FAIL order_drain: %0d outstanding, required 0", left); end
    checks++; if (di_hist.size() - db != 9) begin failures++; $display("FAIL order_len: %0d DI values, required 9", di_hist.size() - db); end
    for (int i = 0; i < 9; i++) begin
      e = 8'(9 - i);
      checks++;
      if (di_hist[db + i] !== e) begin
        failures++;
        $display("FAIL order_di[%0d]: %0d, required %0d", i, di_hist[db + i], e);
      end
    end
    checks++; if (RES_OUT !== 8'd5) begin failures++; $display("FAIL order_res: %0d, required 5", RES_OUT); end
  endtask

  task automatic test_timeout();
    int rb = res_hist.size();
    int eb = err_cyc.size();
    int n = 0;
    int waited;
    bit seen = 1'b0;
    model_en = 1'b0;
    err_allowed = 1'b1;
    fill_random();
    send_img(3, 2, 1'b0, 1'b0);
    while (!seen && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
      if (RES_ERR === 1'b1) seen = 1'b1;
    end
    waited = cyc - last_dsi_cyc;
    checks++; if (!seen) begin failures++; $display("FAIL tmo_err: RES_ERR never seen in %0d cycles, required pulse", n); end
    checks++; if (waited != 63) begin failures++; $display("FAIL tmo_cycles: %0d WAIT cycles, required 63", waited); end
    checks++; if (RES_OUT !== last_exp) begin failures++; $display("FAIL tmo_res_out: %0d, required %0d", RES_OUT, last_exp); end
    checks++; if (PIX_RDY !== 1'b0) begin failures++; $display("FAIL tmo_rdy_err: %b, required 0", PIX_RDY); end
    @(negedge CLK);
    #1;
    checks++; if (PIX_RDY !== 1'b1) begin failures++; $display("FAIL tmo_rdy_next: %b, required 1", PIX_RDY); end
    checks++; if (RES_ERR !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse: %b, required 0", RES_ERR); end
    checks++; if (res_hist.size() != rb) begin failures++; $display("FAIL tmo_res_val: %0d results, required 0", res_hist.size() - rb); end
    checks++; if (err_cyc.size() - eb != 1) begin failures++; $display("FAIL tmo_err_count: %0d, required 1", err_cyc.size() - eb); end
    model_en = 1'b1;
    err_allowed = 1'b0;
  endtask

  task automatic test_back_to_back();
    int ab = acc_hist.size();
    int rb = res_hist.size();
    int left;
    src_q.delete();
    fill_random();
    send_img(3, 15, 1'b0, 1'b1);
    wait_idle(left);
    checks++; if (left != 0) begin failures++; $display("FAIL b2b_drain: %0d outstanding, required 0", left); end
    checks++; if (res_hist.size() - rb != 14) begin failures++; $display("FAIL b2b_count: %0d, required 14", res_hist.size() - rb); end
    checks++; if (acc_hist.size() - ab != src_q.size()) begin failures++; $display("FAIL b2b_accepted: %0d, required %0d", acc_hist.size() - ab, src_q.size()); end
    for (int i = 0; i < src_q.size(); i++) begin
      checks++;
      if (acc_hist[ab + i] !== src_q[i]) begin
        failures++;
        $display("FAIL b2b_pixel[%0d]: %0d, required %0d", i, acc_hist[ab + i], src_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    fill_random();
    send_img(3, 2, 1'b0, 1'b0);
    checks++; if (MED_DSI !== 1'b1) begin failures++; $display("FAIL mid_latency: MED_DSI=%b, required 1", MED_DSI); end
    checks++; if (MED_DI !== img[0][0]) begin failures++; $display("FAIL mid_di0: %0d, required %0d", MED_DI, img[0][0]); end
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (MED_DI !== img[1][1]) begin failures++; $display("FAIL mid_di4: %0d, required %0d", MED_DI, img[1][1]); end
    nRST = 1'b0;
    #1;
    checks++; if (MED_DSI !== 1'b0) begin failures++; $display("FAIL mid_dsi: %b, required 0", MED_DSI); end
    checks++; if (MED_DI !== 8'd0) begin failures++; $display("FAIL mid_di: %0d, required 0", MED_DI); end
    checks++; if (RES_OUT !== 8'd0) begin failures++; $display("FAIL mid_res_out: %0d, required 0", RES_OUT); end
    checks++; if (RES_VAL !== 1'b0) begin failures++; $display("FAIL mid_res_val: %b, required 0", RES_VAL); end
    checks++; if (RES_ERR !== 1'b0) begin failures++; $display("FAIL mid_res_err: %b, required 0", RES_ERR); end
    checks++; if (PIX_RDY !== 1'b0) begin failures++; $display("FAIL mid_pix_rdy: %b, required 0", PIX_RDY); end
    last_exp = 8'd0;
    repeat (3) @(posedge CLK);
    #1 nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic test_sof_mid();
    int sb0 = dsi_start_acc.size();
    int rb;
    int base;
    int left;
    int got;
    fill_ramp();
    send_img(2, 4, 1'b0, 1'b0);
    base = acc_total;
    rb = res_hist.size();
    fill_random();
    send_img(3, 15, 1'b0, 1'b1);
    wait_idle(left);
    got = (dsi_start_acc.size() > sb0) ? dsi_start_acc[sb0] - base : -1;
    checks++; if (got != 35) begin failures++; $display("FAIL sof_first_window: after %0d pixels, required 35", got); end
    checks++; if (left != 0) begin failures++; $display("FAIL sof_drain: %0d outstanding, required 0", left); end
    checks++; if (res_hist.size() - rb != 14) begin failures++; $display("FAIL sof_count: %0d, required 14", res_hist.size() - rb); end
  endtask

  initial begin
    nRST    = 1'b1;
    PIX_VAL = 1'b0;
    PIX_IN  = 8'd0;
    SOF     = 1'b0;
    test_reset();
    test_frame();
    test_window_order();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    test_frame();
    test_sof_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
